// File: rtl/irrigation_actuator.sv
// Irrigation valve/pump sequencer driven by a debounced tank-controller code.
// Optional FAULT entry counter enabled by IRRIGATION_ACTUATOR_ERR_COUNT_EN.
module irrigation_actuator #(
    parameter int unsigned STABLE_CYC  = 4,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned MIN_OFF_CYC = 16,
    parameter int unsigned BLINK_HALF  = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] state_in,
    input  logic       fault_clr,
    output logic       valve_open,
    output logic       pump_on,
    output logic       alarm,
    output logic [2:0] mode,
    output logic [7:0] err_count
);

    localparam int unsigned FW = 4;
    localparam int unsigned CW = 8;

    localparam logic [1:0] CMD_VZ   = 2'b00;
    localparam logic [1:0] CMD_EN   = 2'b01;
    localparam logic [1:0] CMD_ERRO = 2'b10;
    localparam logic [1:0] CMD_REGA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_FILL     = 3'b001,
        ST_SETTLE   = 3'b010,
        ST_IRRIGATE = 3'b011,
        ST_FAULT    = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    samp_q, samp_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [FW-1:0] filt_q, filt_d;
    logic [CW-1:0] settle_q, settle_d, settle_inc;
    logic [CW-1:0] off_q, off_d;
    logic [CW-1:0] blink_q, blink_d, blink_inc;
    logic          alarm_q, alarm_d;
    logic          fault_entry;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            samp_q   <= CMD_VZ;
            cmd_q    <= CMD_VZ;
            filt_q   <= '0;
            settle_q <= '0;
            off_q    <= CW'(MIN_OFF_CYC);
            blink_q  <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            samp_q   <= samp_d;
            cmd_q    <= cmd_d;
            filt_q   <= filt_d;
            settle_q <= settle_d;
            off_q    <= off_d;
            blink_q  <= blink_d;
            alarm_q  <= alarm_d;
        end
    end

    always_comb begin
        samp_d      = state_in;
        cmd_d       = cmd_q;
        filt_d      = FW'(1);
        state_d     = state_q;
        settle_d    = '0;
        off_d       = '0;
        blink_d     = '0;
        alarm_d     = 1'b0;
        fault_entry = 1'b0;
        settle_inc  = (settle_q >= CW'(SETTLE_CYC)) ? CW'(SETTLE_CYC) : settle_q + CW'(1);
        blink_inc   = blink_q + CW'(1);

        // Run-length debounce: the edge completing STABLE_CYC equal samples commits cmd.
        if (state_in == samp_q) begin
            filt_d = (filt_q >= FW'(STABLE_CYC)) ? FW'(STABLE_CYC) : filt_q + FW'(1);
        end
        if (filt_d == FW'(STABLE_CYC)) begin
            cmd_d = state_in;
        end

        if (!pump_on) begin
            off_d = (off_q >= CW'(MIN_OFF_CYC)) ? CW'(MIN_OFF_CYC) : off_q + CW'(1);
        end

        if (cmd_q == CMD_ERRO && state_q != ST_FAULT) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_q == CMD_EN)        state_d = ST_FILL;
                    else if (cmd_q == CMD_REGA) state_d = ST_SETTLE;
                end
                ST_FILL: begin
                    if (cmd_q == CMD_VZ)        state_d = ST_IDLE;
                    else if (cmd_q == CMD_REGA) state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cmd_q == CMD_VZ)      state_d = ST_IDLE;
                    else if (cmd_q == CMD_EN) state_d = ST_FILL;
                    else if (settle_inc == CW'(SETTLE_CYC) && off_d >= CW'(MIN_OFF_CYC))
                        state_d = ST_IRRIGATE;
                end
                ST_IRRIGATE: begin
                    if (cmd_q == CMD_VZ)      state_d = ST_IDLE;
                    else if (cmd_q == CMD_EN) state_d = ST_FILL;
                end
                ST_FAULT: begin
                    if (fault_clr && cmd_q != CMD_ERRO) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_q == ST_SETTLE && state_d == ST_SETTLE) begin
            settle_d = settle_inc;
        end

        // Lamp lights on entry, then flips each time BLINK_HALF edges have elapsed.
        if (state_d == ST_FAULT) begin
            if (state_q != ST_FAULT) begin
                fault_entry = 1'b1;
                alarm_d     = 1'b1;
            end else if (blink_inc == CW'(BLINK_HALF)) begin
                alarm_d = ~alarm_q;
            end else begin
                alarm_d = alarm_q;
                blink_d = blink_inc;
            end
        end
    end

`ifdef IRRIGATION_ACTUATOR_ERR_COUNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (fault_entry && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

    assign valve_open = (state_q == ST_FILL);
    assign pump_on    = (state_q == ST_IRRIGATE);
    assign alarm      = alarm_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_irrigation_actuator.sv
// Self-checking bench for irrigation_actuator: vector table, blink sequence,
// randomized traffic against a behavioural model, and fault-counter saturation.
module tb_irrigation_actuator;

    localparam int STABLE = 4;
    localparam int SETTLE = 8;
    localparam int MINOFF = 16;
    localparam int BLINK  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] si  = 2'b00;
    logic       fc  = 1'b0;
    logic       valve_open, pump_on, alarm;
    logic [2:0] mode;
    logic [7:0] err_count;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  auto_chk = 1'b0;

    irrigation_actuator #(
        .STABLE_CYC (STABLE),
        .SETTLE_CYC (SETTLE),
        .MIN_OFF_CYC(MINOFF),
        .BLINK_HALF (BLINK)
    ) dut (
        .clock     (clk),
        .reset     (rst),
        .state_in  (si),
        .fault_clr (fc),
        .valve_open(valve_open),
        .pump_on   (pump_on),
        .alarm     (alarm),
        .mode      (mode),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain counters of edges, sample history queue.
    int         m_mode;
    logic [1:0] m_cmd;
    logic [1:0] hist[$];
    int         m_settle;
    int         m_off;
    int         m_fault_k;
    int         m_err;
    bit         m_alarm;

    function automatic int err_exp(int n);
`ifdef IRRIGATION_ACTUATOR_ERR_COUNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0;
`endif
    endfunction

    function automatic void model_step(bit r, logic [1:0] s, bit f);
        int  nm;
        int  new_off;
        bit  same;
        if (r) begin
            m_mode = 0; m_cmd = 2'b00; hist.delete();
            m_settle = 0; m_off = MINOFF; m_fault_k = 0; m_err = 0; m_alarm = 0;
            return;
        end
        new_off = (m_mode == 3) ? 0 : m_off + 1;
        nm = m_mode;
        if (m_cmd == 2'b10 && m_mode != 4) nm = 4;
        else case (m_mode)
            0: if (m_cmd == 2'b01) nm = 1; else if (m_cmd == 2'b11) nm = 2;
            1: if (m_cmd == 2'b00) nm = 0; else if (m_cmd == 2'b11) nm = 2;
            2: if (m_cmd == 2'b00) nm = 0; else if (m_cmd == 2'b01) nm = 1;
               else if (m_settle + 1 >= SETTLE && new_off >= MINOFF) nm = 3;
            3: if (m_cmd == 2'b00) nm = 0; else if (m_cmd == 2'b01) nm = 1;
            default: if (f && m_cmd != 2'b10) nm = 0;
        endcase
        m_settle = (m_mode == 2 && nm == 2) ? m_settle + 1 : 0;
        if (nm == 4) begin
            if (m_mode != 4) begin
                m_fault_k = 0;
                m_err = m_err + 1;
            end else begin
                m_fault_k = m_fault_k + 1;
            end
            m_alarm = ((m_fault_k / BLINK) % 2) == 0;
        end else begin
            m_alarm = 0;
        end
        m_off  = new_off;
        m_mode = nm;
        hist.push_back(s);
        if (hist.size() > STABLE) hist.delete(0);
        if (hist.size() == STABLE) begin
            same = 1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 0;
            if (same) m_cmd = hist[0];
        end
    endfunction

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void check_model(string tag);
        chk({tag, ".mode"},  int'(mode),       m_mode);
        chk({tag, ".valve"}, int'(valve_open), (m_mode == 1) ? 1 : 0);
        chk({tag, ".pump"},  int'(pump_on),    (m_mode == 3) ? 1 : 0);
        chk({tag, ".alarm"}, int'(alarm),      int'(m_alarm));
        chk({tag, ".err"},   int'(err_count),  err_exp(m_err));
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step(rst, si, fc);
        #1;
        if (auto_chk) check_model("rand");
    endtask

    typedef struct {
        bit         rst;
        logic [1:0] si;
        bit         fc;
        int         hold;
        int         mode;
        bit         valve;
        bit         pump;
        bit         alarm;
        int         nerr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // rst si fc hold | mode valve pump alarm faults-since-reset
        tbl.push_back('{1, 2'b00, 0, 2,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 4,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 1,  1, 1, 0, 0, 0});
        tbl.push_back('{0, 2'b10, 0, 3,  1, 1, 0, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 4,  1, 1, 0, 0, 0});
        tbl.push_back('{0, 2'b10, 0, 4,  1, 1, 0, 0, 0});
        tbl.push_back('{0, 2'b10, 0, 1,  4, 0, 0, 1, 1});
        tbl.push_back('{0, 2'b10, 1, 5,  4, 0, 0, 1, 1});
        tbl.push_back('{0, 2'b00, 1, 4,  4, 0, 0, 1, 1});
        tbl.push_back('{0, 2'b00, 1, 1,  0, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 5,  2, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 7,  2, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 1,  3, 0, 1, 0, 1});
        tbl.push_back('{0, 2'b00, 0, 4,  3, 0, 1, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 1,  0, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 3,  0, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 1,  2, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 11, 2, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 1,  3, 0, 1, 0, 1});
        tbl.push_back('{0, 2'b00, 0, 5,  0, 0, 0, 0, 1});
        tbl.push_back('{0, 2'b11, 0, 5,  2, 0, 0, 0, 1});
        tbl.push_back('{1, 2'b11, 0, 1,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 2'b11, 0, 1,  0, 0, 0, 0, 0});
        tbl.push_back('{0, 2'b10, 0, 5,  4, 0, 0, 1, 1});
        tbl.push_back('{1, 2'b10, 0, 1,  0, 0, 0, 0, 0});

        foreach (tbl[i]) begin
            rst = tbl[i].rst; si = tbl[i].si; fc = tbl[i].fc;
            repeat (tbl[i].hold) tick();
            chk($sformatf("row%0d.mode", i),  int'(mode),       tbl[i].mode);
            chk($sformatf("row%0d.valve", i), int'(valve_open), int'(tbl[i].valve));
            chk($sformatf("row%0d.pump", i),  int'(pump_on),    int'(tbl[i].pump));
            chk($sformatf("row%0d.alarm", i), int'(alarm),      int'(tbl[i].alarm));
            chk($sformatf("row%0d.err", i),   int'(err_count),  err_exp(tbl[i].nerr));
        end

        // Alarm blink period from a fresh FAULT entry.
        rst = 0; si = 2'b10; fc = 0;
        repeat (5) tick();
        chk("blink.entry_mode", int'(mode), 4);
        chk("blink.entry_alarm", int'(alarm), 1);
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk($sformatf("blink.k%0d", k), int'(alarm), (k < 32 || k >= 64) ? 1 : 0);
        end

        // Randomized traffic against the model.
        auto_chk = 1'b1;
        for (int s = 0; s < 250; s++) begin
            int r;
            int r2;
            int hold;
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 9);
            rst = (r < 3);
            si  = (r2 < 2) ? 2'b00 : (r2 < 4) ? 2'b01 : (r2 < 5) ? 2'b10 : 2'b11;
            fc  = ($urandom_range(0, 3) == 0);
            hold = rst ? 1 : $urandom_range(1, 30);
            repeat (hold) tick();
        end

        // 256 FAULT entries from a clean reset: counter saturates.
        rst = 1; si = 2'b00; fc = 0;
        tick();
        rst = 0;
        for (int n = 0; n < 256; n++) begin
            si = 2'b10; fc = 0;
            repeat (5) tick();
            si = 2'b00; fc = 1;
            repeat (5) tick();
        end
        auto_chk = 1'b0;
`ifdef IRRIGATION_ACTUATOR_ERR_COUNT_EN
        chk("sat.err_count", int'(err_count), 255);
`else
        chk("sat.err_count", int'(err_count), 0);
`endif
        chk("sat.mode", int'(mode), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
